// File: rtl/mem_access_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_pkg: shared types and defaults for the memory controller|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mem_access_pkg;

  localparam int DEF_INST_WORDS = 50;
  localparam int DEF_MEM_WORDS  = 89;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD        = 3'd1,
    S_WR_SETUP  = 3'd2,
    S_WR_STROBE = 3'd3,
    S_WR_HOLD   = 3'd4,
    S_RESP      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } access_kind_e;

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_ctrl_if: datapath request and memory bus bundle         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface mem_access_ctrl_if #(
  parameter int N = 32
);
  logic         if_req;
  logic [N-1:0] if_pc;
  logic         if_ready;
  logic [N-1:0] if_instr;
  logic         d_req;
  logic         d_we;
  logic [N-1:0] d_addr;
  logic [N-1:0] d_wdata;
  logic         d_ready;
  logic [N-1:0] d_rdata;
  logic         err;
  logic [N-1:0] mem_adr;
  logic [N-1:0] mem_data_in;
  logic [N-1:0] mem_data_out;
  logic         mem_write;
  logic         for_data_mem;

  // slave: the controller; master: the datapath plus memory around it
  modport slave (
    input  if_req, if_pc, d_req, d_we, d_addr, d_wdata, mem_data_out,
    output if_ready, if_instr, d_ready, d_rdata, err,
           mem_adr, mem_data_in, mem_write, for_data_mem
  );

  modport master (
    output if_req, if_pc, d_req, d_we, d_addr, d_wdata, mem_data_out,
    input  if_ready, if_instr, d_ready, d_rdata, err,
           mem_adr, mem_data_in, mem_write, for_data_mem
  );
endinterface
`default_nettype wire

// File: rtl/mem_range_check.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_range_check: combinational legality check for one access       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_range_check
  import mem_access_pkg::*;
#(
  parameter int N          = 32,
  parameter int INST_WORDS = DEF_INST_WORDS,
  parameter int MEM_WORDS  = DEF_MEM_WORDS
) (
  input  access_kind_e kind,
  input  logic [N-1:0] addr,
  input  logic         we,
  output logic         ok
);

  localparam logic [N-1:0] c_inst_lim = N'(INST_WORDS);
  localparam logic [N-1:0] c_mem_lim  = N'(MEM_WORDS);

  logic w_is_store;

  assign w_is_store = we | (kind == STORE);

  // Fetches are byte addresses; data accesses are word indices.
  always_comb begin
    ok = 1'b0;
    unique case (kind)
      FETCH:       ok = (addr[1:0] == 2'b00) && ((addr >> 2) < c_inst_lim);
      LOAD, STORE: ok = (addr < c_mem_lim) && (!w_is_store || (addr >= c_inst_lim));
      default:     ok = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_ctrl: fetch/load/store arbiter and sequencer for the    |
// | unified main memory of the multi-cycle core.   Rev 1.0             |
// +--------------------------------------------------------------------+
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int N          = 32,
  parameter int INST_WORDS = DEF_INST_WORDS,
  parameter int MEM_WORDS  = DEF_MEM_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.slave  bus
);

  state_e       r_state;
  state_e       w_next;
  access_kind_e r_kind;
  access_kind_e w_kind;
  logic [N-1:0] w_addr;
  logic         w_accept;
  logic         w_ok;
  logic         r_rej;

  logic [N-1:0] r_mem_adr;
  logic [N-1:0] r_mem_data_in;
  logic [N-1:0] r_if_instr;
  logic [N-1:0] r_d_rdata;
  logic         r_mem_write;
  logic         r_for_data_mem;
  logic         r_if_ready;
  logic         r_d_ready;
  logic         r_err;

  assign w_accept = bus.d_req | bus.if_req;

  // Data side wins when both requests are present.
  always_comb begin
    w_kind = FETCH;
    w_addr = bus.if_pc;
    if (bus.d_req) begin
      w_kind = bus.d_we ? STORE : LOAD;
      w_addr = bus.d_addr;
    end
  end

  mem_range_check #(
    .N          (N),
    .INST_WORDS (INST_WORDS),
    .MEM_WORDS  (MEM_WORDS)
  ) u_range_check (
    .kind (w_kind),
    .addr (w_addr),
    .we   (bus.d_req & bus.d_we),
    .ok   (w_ok)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_ok)                w_next = S_RESP;
          else if (w_kind == STORE) w_next = S_WR_SETUP;
          else                      w_next = S_RD;
        end
      end
      S_RD:        w_next = S_RESP;
      S_WR_SETUP:  w_next = S_WR_STROBE;
      S_WR_STROBE: w_next = S_WR_HOLD;
      S_WR_HOLD:   w_next = S_RESP;
      S_RESP:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_kind         <= FETCH;
      r_rej          <= 1'b0;
      r_mem_adr      <= '0;
      r_mem_data_in  <= '0;
      r_if_instr     <= '0;
      r_d_rdata      <= '0;
      r_mem_write    <= 1'b0;
      r_for_data_mem <= 1'b0;
      r_if_ready     <= 1'b0;
      r_d_ready      <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state     <= w_next;
      // Strobe is decoded from the next state so it is a clean flop output.
      r_mem_write <= (w_next == S_WR_STROBE);
      // Ready/err are registered from RESP, so they appear the cycle after it.
      r_if_ready  <= (r_state == S_RESP) && (r_kind == FETCH);
      r_d_ready   <= (r_state == S_RESP) && (r_kind != FETCH);
      r_err       <= (r_state == S_RESP) && r_rej;

      if ((r_state == S_IDLE) && w_accept) begin
        r_kind <= w_kind;
        r_rej  <= !w_ok;
        if (w_ok) begin
          r_mem_adr      <= w_addr;
          r_for_data_mem <= (w_kind != FETCH);
          if (w_kind == STORE) r_mem_data_in <= bus.d_wdata;
        end else if (w_kind == LOAD) begin
          r_d_rdata <= '0;
        end
      end

      if (r_state == S_RD) begin
        if (r_kind == FETCH) r_if_instr <= bus.mem_data_out;
        else                 r_d_rdata  <= bus.mem_data_out;
      end
    end
  end

  assign bus.mem_adr      = r_mem_adr;
  assign bus.mem_data_in  = r_mem_data_in;
  assign bus.mem_write    = r_mem_write;
  assign bus.for_data_mem = r_for_data_mem;
  assign bus.if_instr     = r_if_instr;
  assign bus.d_rdata      = r_d_rdata;
  assign bus.if_ready     = r_if_ready;
  assign bus.d_ready      = r_d_ready;
  assign bus.err          = r_err;

endmodule
`default_nettype wire
